// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer:
// mode encodings, initial masks, and the ms-to-cycles helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_HALF   = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [7:0] INIT_HALF   = 8'h0F;
    localparam logic [7:0] INIT_CHASE  = 8'h01;
    localparam logic [7:0] INIT_BOUNCE = 8'h01;
    localparam logic [7:0] INIT_BLINK  = 8'hFF;

    function automatic int ms_to_cycles(
        input int clk_hz,
        input int ms
    );
        return clk_hz / 1000 * ms;
    endfunction

    function automatic logic [7:0] init_mask(
        input mode_e m
    );
        logic [7:0] r;
        unique case (m)
            MODE_HALF:   r = INIT_HALF;
            MODE_CHASE:  r = INIT_CHASE;
            MODE_BOUNCE: r = INIT_BOUNCE;
            MODE_BLINK:  r = INIT_BLINK;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_press_classifier.sv
// Classifies debounced button presses into short and long events.
// Ports: clk, rst (async active-low), btn_level in; short_evt, long_evt 1-cycle pulses out.
module press_classifier
    import led_pkg::*;
#(
    parameter int LONG_CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic short_evt,
    output logic long_evt
);

    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

    logic          btn_prev;
    logic          idle_seen;
    logic          armed;
    logic          long_done;
    logic [HW-1:0] hold;
    logic          rise;
    logic          fall;

    // idle_seen blocks arming until the button has been seen released
    // after reset, so a press held through reset never generates events.
    assign rise = btn_level & ~btn_prev & idle_seen;
    assign fall = ~btn_level & btn_prev;

    assign long_evt  = btn_level & armed & ~rise & ~long_done
                     & (hold == HOLD_LAST);
    assign short_evt = fall & armed & ~long_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev  <= 1'b0;
            idle_seen <= 1'b0;
            armed     <= 1'b0;
            long_done <= 1'b0;
            hold      <= '0;
        end else begin
            btn_prev <= btn_level;
            if (!btn_level) begin
                idle_seen <= 1'b1;
            end
            if (rise) begin
                armed     <= 1'b1;
                hold      <= '0;
                long_done <= 1'b0;
            end else if (btn_level && armed) begin
                if (hold != HOLD_MAX) begin
                    hold <= hold + 1'b1;
                end
                if (long_evt) begin
                    long_done <= 1'b1;
                end
            end
            if (fall) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Timed LED pattern scheduler: button short press cycles mode, long press freezes.
// Ports: clk, rst (async active-low), btn_level in; led_out[7:0], mode[1:0], frozen out.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 10_000_000,
    parameter int STEP_MS        = 125,
    parameter int LONG_PRESS_MS  = 1000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_level,
    output logic [7:0] led_out,
    output logic [1:0] mode,
    output logic       frozen
);

    localparam int STEP_CYC = ms_to_cycles(CLK_FREQ_HZ, STEP_MS);
    localparam int LONG_CYC = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
    localparam int PW = $clog2(STEP_CYC);
    localparam logic [PW-1:0] STEP_LAST = PW'(STEP_CYC - 1);
    localparam logic [7:0] LED_RST = LED_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic short_evt;
    logic long_evt;
    logic tick;

    mode_e         mode_q, mode_d;
    dir_e          dir_q, dir_d;
    logic [7:0]    lit_q, lit_d;
    logic          frozen_q, frozen_d;
    logic [PW-1:0] presc_q, presc_d;

    press_classifier #(
        .LONG_CYC (LONG_CYC)
    ) u_press (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .short_evt (short_evt),
        .long_evt  (long_evt)
    );

    assign tick = ~frozen_q & (presc_q == STEP_LAST);

    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        lit_d    = lit_q;
        frozen_d = frozen_q;
        presc_d  = presc_q + 1'b1;

        if (frozen_q || tick) begin
            presc_d = '0;
        end
        if (long_evt) begin
            frozen_d = ~frozen_q;
        end

        // A mode change overrides a coincident step.
        if (short_evt) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            lit_d   = init_mask(mode_d);
            dir_d   = DIR_LEFT;
            presc_d = '0;
        end else if (tick) begin
            unique case (mode_q)
                MODE_HALF, MODE_BLINK: begin
                    lit_d = ~lit_q;
                end
                MODE_CHASE: begin
                    lit_d = {lit_q[6:0], lit_q[7]};
                end
                MODE_BOUNCE: begin
                    // Turn around at the ends without repeating the end LED.
                    if (dir_q == DIR_LEFT) begin
                        if (lit_q[7]) begin
                            dir_d = DIR_RIGHT;
                            lit_d = lit_q >> 1;
                        end else begin
                            lit_d = lit_q << 1;
                        end
                    end else begin
                        if (lit_q[0]) begin
                            dir_d = DIR_LEFT;
                            lit_d = lit_q << 1;
                        end else begin
                            lit_d = lit_q >> 1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= MODE_HALF;
            dir_q    <= DIR_LEFT;
            lit_q    <= INIT_HALF;
            frozen_q <= 1'b0;
            presc_q  <= '0;
            led_out  <= LED_RST;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            lit_q    <= lit_d;
            frozen_q <= frozen_d;
            presc_q  <= presc_d;
            led_out  <= LED_ACTIVE_LOW ? ~lit_q : lit_q;
        end
    end

    assign mode   = mode_q;
    assign frozen = frozen_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with hand-computed expectations.
// Uses STEP_CYC=4 and LONG_CYC=20 so patterns and long presses stay short.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst;
    logic       btn_level;
    logic [7:0] led_out;
    logic [1:0] mode;
    logic       frozen;

    int n_checks;
    int n_fail;

    led_pattern_sequencer #(
        .CLK_FREQ_HZ    (1000),
        .STEP_MS        (4),
        .LONG_PRESS_MS  (20),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .led_out   (led_out),
        .mode      (mode),
        .frozen    (frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string      tag,
        input logic [7:0] got,
        input logic [7:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ends one cycle after reset release, button low.
    task automatic do_reset();
        rst       = 1'b0;
        btn_level = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Returns just after the release edge.
    task automatic press(input int n);
        btn_level = 1'b1;
        repeat (n) step();
        btn_level = 1'b0;
        step();
    endtask

    function automatic logic [7:0] bounce_led(input int j);
        logic [7:0] one;
        int         p;
        int         pos;
        one = 8'h01;
        p   = ((j - 1) / 4) % 14;
        pos = (p < 8) ? p : 14 - p;
        return ~(one << pos);
    endfunction

    initial begin
        logic [7:0] one;
        logic [7:0] e;
        one       = 8'h01;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        btn_level = 1'b0;

        // 1: reset values and HALF pattern
        repeat (3) begin
            step();
            check("rst_led", led_out, 8'hFF);
            check("rst_mode", {6'd0, mode}, 8'd0);
            check("rst_frozen", {7'd0, frozen}, 8'd0);
        end
        rst = 1'b1;
        step();
        check("half_first", led_out, 8'hF0);
        for (int j = 2; j <= 12; j++) begin
            step();
            e = (((j - 1) / 4) % 2 != 0) ? 8'h0F : 8'hF0;
            check("half_seq", led_out, e);
        end
        check("half_mode", {6'd0, mode}, 8'd0);

        // 2: short press into CHASE
        do_reset();
        press(5);
        check("chase_mode", {6'd0, mode}, 8'd1);
        for (int j = 1; j <= 36; j++) begin
            step();
            e = ~(one << (((j - 1) / 4) % 8));
            check("chase_seq", led_out, e);
        end

        // 3: BOUNCE
        do_reset();
        press(2);
        check("b_mode1", {6'd0, mode}, 8'd1);
        press(2);
        check("b_mode2", {6'd0, mode}, 8'd2);
        for (int j = 1; j <= 64; j++) begin
            step();
            check("bounce_seq", led_out, bounce_led(j));
        end

        // 4: long press freeze / unfreeze
        do_reset();
        btn_level = 1'b1;
        step();
        check("lp_rise", {7'd0, frozen}, 8'd0);
        repeat (19) step();
        check("lp_19", {7'd0, frozen}, 8'd0);
        step();
        check("lp_20", {7'd0, frozen}, 8'd1);
        repeat (4) step();
        btn_level = 1'b0;
        step();
        check("lp_mode", {6'd0, mode}, 8'd0);
        check("lp_frz", {7'd0, frozen}, 8'd1);
        for (int j = 0; j < 50; j++) begin
            step();
            check("frozen_led", led_out, 8'h0F);
        end
        btn_level = 1'b1;
        step();
        repeat (19) step();
        check("lp2_19", {7'd0, frozen}, 8'd1);
        step();
        check("lp2_20", {7'd0, frozen}, 8'd0);
        repeat (2) step();
        btn_level = 1'b0;
        step();
        check("lp2_mode", {6'd0, mode}, 8'd0);
        step();
        check("resume_hold", led_out, 8'h0F);
        step();
        check("resume_step", led_out, 8'hF0);

        // 5: press held through reset, then async reset mid-CHASE
        rst       = 1'b0;
        btn_level = 1'b1;
        step();
        step();
        rst = 1'b1;
        repeat (4) step();
        btn_level = 1'b0;
        step();
        check("held_mode", {6'd0, mode}, 8'd0);
        repeat (3) step();
        check("held_mode2", {6'd0, mode}, 8'd0);
        press(2);
        check("after_held", {6'd0, mode}, 8'd1);
        repeat (2) step();
        check("pre_async", led_out, 8'hFE);
        #3;
        rst = 1'b0;
        #1;
        check("async_led", led_out, 8'hFF);
        check("async_mode", {6'd0, mode}, 8'd0);
        check("async_frz", {7'd0, frozen}, 8'd0);

        // 6: mode wrap, BLINK, short press on a tick
        do_reset();
        press(2);
        check("w_mode1", {6'd0, mode}, 8'd1);
        press(2);
        check("w_mode2", {6'd0, mode}, 8'd2);
        press(2);
        check("w_mode3", {6'd0, mode}, 8'd3);
        for (int j = 1; j <= 16; j++) begin
            step();
            e = (((j - 1) / 4) % 2 != 0) ? 8'hFF : 8'h00;
            check("blink_seq", led_out, e);
        end
        press(3);
        check("w_mode0", {6'd0, mode}, 8'd0);
        step();
        check("tick_win", led_out, 8'hF0);
        repeat (3) step();
        check("tick_win4", led_out, 8'hF0);
        step();
        check("tick_win5", led_out, 8'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Controller that owns the 8-bit board LED bank and sequences it through four display modes using a single debounced push button. A short press advances the mode. A long press freezes or unfreezes the running pattern. It sits downstream of debounce_ip_core (debounced level output) and drives the active-low LED pins directly. It replaces ad-hoc per-design LED logic with one timed pattern scheduler.

Parameters:
CLK_FREQ_HZ, 10_000_000, system clock frequency in Hz.
STEP_MS, 125, pattern step period in ms; STEP_CYC = CLK_FREQ_HZ/1000*STEP_MS, must be >= 2.
LONG_PRESS_MS, 1000, hold time that classifies a press as long; LONG_CYC = CLK_FREQ_HZ/1000*LONG_PRESS_MS, must be >= 2.
LED_ACTIVE_LOW, 1, 1 means led_out = ~lit, 0 means led_out = lit.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-low.
btn_level  in  1  debounced button level, already synchronous to clk, 1 = pressed.
led_out  out  8  registered LED drive.
mode  out  2  current mode: 0 HALF, 1 CHASE, 2 BOUNCE, 3 BLINK.
frozen  out  1  1 = pattern stepping halted.

Behaviour:
- Reset is clk and rst: asynchronous, active-low. Reset values:
  - led_out = 8'hFF (all off when LED_ACTIVE_LOW=1, else 8'h00).
  - mode = 0, frozen = 0, lit = 8'h0F, dir = left.
  - prescaler = 0, hold counter = 0, btn_prev = 0, armed = 0, long_done = 0.
  - All of these take effect immediately when rst asserts.
- Press classifier:
  - btn_prev is a register of btn_level.
  - Rising edge (btn_level=1, btn_prev=0): sets armed=1, clears hold count and long_done.
  - While btn_level=1 and armed: hold count increments, saturating at LONG_CYC.
  - On the edge where hold count becomes LONG_CYC: long event fires once and long_done is set.
  - Falling edge (btn_level=0, btn_prev=1) with armed=1 and long_done=0: short event fires.
  - Any falling edge clears armed.
  - A button already held when reset deasserts is never armed, so no event is generated until a fresh press.
- Short event: mode advances by 1 on that clk edge, wrapping 3 -> 0. Loaded on the same edge:
  - lit = initial mask of the new mode.
  - dir = left.
  - prescaler = 0.
- Long event: frozen toggles on that clk edge. Mode and lit are unchanged.
- Step tick:
  - Prescaler counts 0..STEP_CYC-1 and ticks when at STEP_CYC-1.
  - While frozen=1, the prescaler is held at 0 and there are no ticks.
- Patterns (lit mask, 1 = LED on), one step per tick:
  - HALF: initial 0x0F, alternates 0x0F <-> 0xF0.
  - CHASE: initial 0x01, rotate left, 0x80 -> 0x01.
  - BOUNCE: initial 0x01, shift in dir. Direction reverses at 0x80 and at 0x01, so the sequence is 01,02,...,80,40,...,01,02. There is no repeat at either end.
  - BLINK: initial 0xFF, alternates 0xFF <-> 0x00.
- Simultaneous short event and tick: the mode change wins and lit loads the new initial mask.
- A mode change while frozen is allowed: the initial mask is shown and frozen stays 1.
- Output: led_out is registered from lit with 1-cycle latency. The first clk edge after reset release gives led_out = ~0x0F = 0xF0 (active-low).
- mode and frozen are direct register outputs.

Decomposition:
- Shared package led_pkg holds:
  - mode constants MODE_HALF/CHASE/BOUNCE/BLINK (2-bit).
  - Initial-mask constants.
  - Function ms_to_cycles(clk_hz, ms).
- One sub-module is natural: press_classifier.
  - Inputs: clk, rst, btn_level. Parameter: LONG_CYC.
  - Outputs: short_evt, long_evt, each a 1-cycle pulse.
- Prescaler and pattern FSM stay in the top module.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, STEP_MS=4 (STEP_CYC=4), LONG_PRESS_MS=20 (LONG_CYC=20), LED_ACTIVE_LOW=1.
1. Reset low for 3 clks, then release -> led_out=0xFF during reset; 0xF0 after first edge; then 0x0F, 0xF0, ... swapping every 4 clks; mode=0, frozen=0.
2. btn_level high 5 clks, then low -> mode=1 on release edge; led_out=0xFE next clk, then 0xFD, 0xFB, ..., 0x7F, then wraps to 0xFE, 4 clks per step.
3. Two short presses from reset -> mode=2; lit observed 01,02,04,...,80,40,20,...,01,02 (led_out inverted); no duplicate 80 or 01.
4. btn_level high 25 clks -> frozen=1 exactly 20 clks after the rising edge; on release mode stays 0 and led_out is constant for 50 clks. Repeat the long press -> frozen=0 and stepping resumes 4 clks later.
5. btn_level held high through reset deassertion, then released -> no mode change. Then assert rst mid-CHASE -> led_out=0xFF and mode=0 immediately (asynchronous).
6. Four short presses -> mode 1,2,3,0. In mode 3, led_out alternates 0x00/0xFF every 4 clks. A short-press release landing on a tick cycle -> new mode's initial mask, not a stepped value.
